// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI memory controller: turns one valid/ready word request into a
// command / quad address / dummy / quad data sequence towards either the
// PSRAM (ce0, sclk_ram) or the NOR flash (ce1, sclk_nor) on a shared sio bus.
module qspi_mem_ctrl #(
  parameter int RAM_DUMMY = 6,
  parameter int NOR_DUMMY = 6,
  parameter int CE_GAP    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic        nor_sel,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        ce0,
  output logic        ce1,
  output logic        sclk_ram,
  output logic        sclk_nor,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oe
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

  localparam logic [7:0] RAM_DUMMY_LEN = 8'(RAM_DUMMY);
  localparam logic [7:0] NOR_DUMMY_LEN = 8'(NOR_DUMMY);
  localparam logic [7:0] CE_GAP_LEN    = 8'(CE_GAP);

  state_t      state, state_next;
  logic        phase;
  logic [7:0]  cnt;
  logic        dev;
  logic        is_read;
  logic [23:0] addr_l;
  logic [31:0] wbuf;
  logic [7:0]  data_last;
  logic [31:0] rbuf;
  logic [31:0] rbuf_next;
  logic [7:0]  gap;

  logic [1:0]  lo_lane, hi_lane;
  logic        accept;
  logic        active;
  logic [7:0]  dummy_len;
  logic [7:0]  cmd_byte;
  logic [4:0]  addr_idx;
  logic [4:0]  nib_idx;
  logic        addr_lsb_unused;

  // The low address bits are replaced by the word alignment or the first strobe lane.
  assign addr_lsb_unused = ^addr[1:0];

  assign accept    = (state == IDLE) && valid && (gap == 8'd0);
  assign active    = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
  assign dummy_len = dev ? NOR_DUMMY_LEN : RAM_DUMMY_LEN;
  assign cmd_byte  = is_read ? 8'hEB : 8'h38;
  assign addr_idx  = 5'd20 - {cnt[2:0], 2'b00};
  // Within a byte the high nibble travels first, so even clocks map to bits [7:4].
  assign nib_idx   = {cnt[2:1], ~cnt[0], 2'b00};

  // Lowest and highest enabled byte lanes bound the write span.
  always_comb begin
    lo_lane = 2'd0;
    hi_lane = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (wstrb[i]) lo_lane = 2'(i);
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) hi_lane = 2'(i);
  end

  // State register with SPI half-clock phase and per-state clock counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      phase <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      phase <= active ? ~phase : 1'b0;
      if (state_next != state)
        cnt <= 8'd0;
      else if (phase)
        cnt <= cnt + 8'd1;
    end
  end

  // Next-state logic: every phase ends on the closing half of its last SPI clock.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = ((wstrb != 4'd0) && nor_sel) ? DONE : CMD;
      CMD:   if (phase && cnt == 8'd7) state_next = ADDR;
      ADDR:  if (phase && cnt == 8'd5)
               state_next = (is_read && dummy_len != 8'd0) ? DUMMY : DATA;
      DUMMY: if (phase && cnt == dummy_len - 8'd1) state_next = DATA;
      DATA:  if (phase && cnt == data_last) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin-side outputs decoded from the current state, counter and phase.
  always_comb begin
    ce0      = !(active && !dev);
    ce1      = !(active && dev);
    sclk_ram = active && !dev && phase;
    sclk_nor = active && dev && phase;
    ready    = (state == DONE);
    sio_o    = 4'h0;
    sio_oe   = 4'h0;
    case (state)
      CMD: begin
        sio_o  = {3'b000, cmd_byte[3'd7 - cnt[2:0]]};
        sio_oe = 4'b0001;
      end
      ADDR: begin
        sio_o  = addr_l[addr_idx +: 4];
        sio_oe = 4'b1111;
      end
      DUMMY: begin
        if (dev && cnt == 8'd0) begin
          sio_o  = 4'hF;
          sio_oe = 4'b1111;
        end else if (dev && cnt == 8'd1) begin
          sio_o  = 4'h0;
          sio_oe = 4'b1111;
        end
      end
      DATA: begin
        if (!is_read) begin
          sio_o  = wbuf[nib_idx +: 4];
          sio_oe = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  // Latch the request on acceptance; writes are pre-shifted so the first lane sits at byte 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dev       <= 1'b0;
      is_read   <= 1'b0;
      addr_l    <= 24'd0;
      wbuf      <= 32'd0;
      data_last <= 8'd0;
    end else if (accept) begin
      dev     <= nor_sel;
      is_read <= (wstrb == 4'd0);
      wbuf    <= wdata >> {lo_lane, 3'b000};
      if (wstrb == 4'd0) begin
        addr_l    <= {addr[23:2], 2'b00};
        data_last <= 8'd7;
      end else begin
        addr_l    <= {addr[23:2], lo_lane};
        data_last <= {5'd0, hi_lane - lo_lane, 1'b1};
      end
    end
  end

  // Incoming nibble merged into the read buffer for the current data clock.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[nib_idx +: 4] = sio_i;
  end

  // Capture read nibbles at the end of each sampling half; publish the word on the last one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rbuf  <= 32'd0;
      rdata <= 32'd0;
    end else if (state == DATA && is_read && phase) begin
      rbuf <= rbuf_next;
      if (cnt == data_last)
        rdata <= rbuf_next;
    end
  end

  // Chip-enable gap: reload when ce rises, count down while ce stays high.
  always_ff @(posedge clk) begin
    if (!resetn)
      gap <= CE_GAP_LEN;
    else if (active && state_next == DONE)
      gap <= CE_GAP_LEN;
    else if ((state == IDLE || state == DONE) && gap != 8'd0)
      gap <= gap - 8'd1;
  end

endmodule

// File: doc/qspi_mem_ctrl.md
Name: qspi_mem_ctrl

Overview:
- Word-oriented quad-SPI memory controller between the SoC bus and the external PSRAM (ce0/sclk_ram) and NOR flash (ce1/sclk_nor), sharing sio[3:0].
- Converts a valid/ready word request into serial command, quad address, dummy and quad data phases.
- Its pin-side outputs drive the chip-level ce0, ce1, sclk_ram, sclk_nor, sio_o, sio_oe signals directly.

Parameters:
- RAM_DUMMY, 6, SPI clocks of wait between address and data for PSRAM read (0xEB).
- NOR_DUMMY, 6, SPI clocks between address and data for NOR read (0xEB); includes the 2 mode-byte clocks.
- CE_GAP, 2, minimum clk cycles chip-enable stays high between transactions.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- valid  in  1  request; held until ready
- ready  out  1  one-cycle completion pulse
- nor_sel  in  1  0 = PSRAM (ce0), 1 = NOR (ce1); stable while valid
- addr  in  24  byte address; stable while valid
- wdata  in  32  write data, little-endian lanes
- wstrb  in  4  byte strobes; 0000 = read
- rdata  out  32  read data, valid at ready, held until next read completes
- ce0, ce1  out  1  active-low chip enables
- sclk_ram, sclk_nor  out  1  SPI clocks; only the selected device's toggles
- sio_i  in  4  quad data in
- sio_o  out  4  quad data out
- sio_oe  out  4  per-line output enable, 1 = drive

Behaviour:
- Reset: ce0 = ce1 = 1, sclk_* = 0, sio_o = 0, sio_oe = 0, ready = 0, rdata = 0, FSM in IDLE, gap counter = CE_GAP.
- Reset asserted mid-transaction: outputs return to reset values at that edge; transaction dropped, no ready.
- SPI clock = clk/2. Each SPI clock is two clk cycles:
  - phase 0: sclk = 0; drive new output bits.
  - phase 1: sclk = 1; inputs sampled on the clk edge that ends phase 1.
- FSM states: IDLE -> CMD (8 clocks, serial MSB-first on sio0, sio_oe = 0001) -> ADDR (6 clocks, quad, addr[23:0] high nibble first, sio_oe = 1111) -> DUMMY (reads only) -> DATA -> DONE -> IDLE.
- Command byte: reads 0xEB on both devices; PSRAM writes 0x38.
- DUMMY:
  - PSRAM: RAM_DUMMY clocks, sio_oe = 0000.
  - NOR: clock 1 drives 4'hF, clock 2 drives 4'h0 (mode byte 0xF0, no continuous read) with sio_oe = 1111; remaining clocks sio_oe = 0000.
- Reads:
  - Always fetch 4 bytes (8 quad clocks) from {addr[23:2], 2'b00}; wstrb = 0.
  - First byte received goes to rdata[7:0]; high nibble arrives first within each byte.
- Writes (PSRAM only):
  - Span runs from the lowest to the highest set strobe lane; start address = {addr[23:2], lowest lane}.
  - 2 quad clocks per byte, high nibble first; intermediate lanes are written even if their strobe is clear.
  - Write with nor_sel = 1: no bus activity; ready pulses the cycle after valid is sampled.
- Timing:
  - valid sampled in IDLE at edge k with gap counter expired: ce low from cycle k+1.
  - After N SPI clocks, ce high and ready = 1 in cycle k+1+2N.
  - PSRAM word read: N = 8 + 6 + 6 + 8 = 28, ready 57 cycles after acceptance.
  - PSRAM word write: N = 8 + 6 + 8 = 22.
- Gap: counter reloads to CE_GAP when ce rises and decrements in IDLE; a request is accepted only when it is 0. A valid present during the gap waits.
- ready is never asserted without valid; valid is not re-sampled in the cycle ready is high.
- sclk of the non-selected device stays 0 throughout; both ce never low together.

Test Plan:
- PSRAM read, addr = 0x001237, slave returns bytes 11 22 33 44 -> sio0 shows 0xEB serial, address nibbles 0,0,1,2,3,4 (aligned 0x001234), rdata = 0x44332211, ready in cycle 57.
- PSRAM write, wstrb = 0100, addr = 0x000100, wdata = 0xAABBCCDD -> cmd 0x38, address 0x000102, single byte 0xBB, N = 16, ready in cycle 33.
- NOR read, nor_sel = 1 -> only ce1/sclk_nor active, mode nibbles F then 0 driven, 4 hi-Z dummy clocks, rdata correct.
- NOR write, wstrb = 1111 -> no ce/sclk activity, ready the next cycle.
- Reset pulsed during ADDR phase -> same-edge ce0 = 1, sio_oe = 0, no ready; a subsequent read completes normally.
- Back-to-back reads, valid held -> ce high for exactly CE_GAP + 1 cycles between transactions (edges counted per Behaviour), wstrb = 0011 write spans 2 bytes.
